enemy_bullet_ctrl: RTL

Downstream consumer of the enemy stage: takes the enemy's fire request and position, spawns enemy bullets into a fixed slot pool, advances them one column per game tick across the 8x8 dot matrix and detects collision with the player. Produces the 64-bit bullet occupancy map consumed by the dot-matrix compositor and a player-hit pulse consumed by the life/score logic.

---
 rtl/raiden_pkg.sv | 17 +
 rtl/enemy_bullet_ctrl_if.sv | 32 +++
 rtl/enemy_bullet_ctrl_tick_sync.sv | 29 ++
 rtl/enemy_bullet_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/raiden_pkg.sv
// Shared game definitions for the raiden dot-matrix blocks.
// Contents: grid size, 3-bit position type, bullet slot record, last column index.
package raiden_pkg;

   localparam int GRID_DIM = 8;

   typedef logic [2:0] pos_t;

   localparam pos_t MAX_COL = 3'd7;

   typedef struct packed {
      logic valid;
      pos_t row;
      pos_t col;
   } bullet_t;

endpackage

// File: rtl/enemy_bullet_ctrl_if.sv
// Signal bundle between the enemy/player stages and enemy_bullet_ctrl.
// Inputs to the controller: fire_req, enemy_row, enemy_col, player_row, player_col
// Outputs from the controller: bullet_map (64-bit occupancy), player_hit,
//   fire_drop (one-clk pulses) and active_cnt.
// There is no valid/ready handshake: every input is a level that the controller
// samples on a game tick, and every output is a registered level or a one-clk pulse.
// modport master: the side that drives the requests and positions.
// modport slave : the bullet controller.
interface enemy_bullet_ctrl_if;
   import raiden_pkg::*;

   logic        fire_req;
   pos_t        enemy_row;
   pos_t        enemy_col;
   pos_t        player_row;
   pos_t        player_col;
   logic [63:0] bullet_map;
   logic        player_hit;
   logic        fire_drop;
   logic [3:0]  active_cnt;

   modport master (
      output fire_req, enemy_row, enemy_col, player_row, player_col,
      input  bullet_map, player_hit, fire_drop, active_cnt
   );

   modport slave (
      input  fire_req, enemy_row, enemy_col, player_row, player_col,
      output bullet_map, player_hit, fire_drop, active_cnt
   );

endinterface

// File: rtl/enemy_bullet_ctrl_tick_sync.sv
// tick_sync: brings the game-tick clock level into the clk domain and turns
// each rising edge into a registered one-clk tick pulse.
// Ports: clk, rst (synchronous, active-low), div_clk (async level in), tick (out).
// All flops clear to 0, so a div_clk that is high right after reset still
// produces exactly one tick.
module tick_sync (
   input  logic clk,
   input  logic rst,
   input  logic div_clk,
   output logic tick
);

   logic sync1, sync2, sync2_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         sync2_d <= 1'b0;
         tick    <= 1'b0;
      end else begin
         sync1   <= div_clk;
         sync2   <= sync1;
         sync2_d <= sync2;
         tick    <= sync2 & ~sync2_d;
      end
   end

endmodule

// File: rtl/enemy_bullet_ctrl.sv
// enemy_bullet_ctrl: spawns enemy bullets into a fixed slot pool, moves them one
// column per game tick, retires them past the last column and (optionally)
// on contact with the player.
// Ports: clk, rst (synchronous, active-low), div_clk (game-tick clock level),
//   bus (enemy_bullet_ctrl_if.slave: fire_req, enemy/player positions in;
//   bullet_map, player_hit, fire_drop, active_cnt out).
// Parameters: NUM_BULLETS (slot count, 1..8), COOLDOWN (ticks between spawns, 0..15).
// Build option: define ENEMY_BULLET_HIT_EN to enable player collision; without
//   it player_hit stays 0 and bullets pass through the player.
module enemy_bullet_ctrl
   import raiden_pkg::*;
#(
   parameter int NUM_BULLETS = 4,
   parameter int COOLDOWN    = 2
) (
   input logic              clk,
   input logic              rst,
   input logic              div_clk,
   enemy_bullet_ctrl_if.slave bus
);

   logic        tick;
   bullet_t     slots_q [NUM_BULLETS];
   bullet_t     slots_n [NUM_BULLETS];
   logic [3:0]  cd_q, cd_n;
   logic [63:0] map_q, map_n;
   logic [3:0]  cnt_q, cnt_n;
   logic        hit_q, hit_n;
   logic        drop_q, drop_n;
   logic        spawn_ok, spawned;

   tick_sync u_tick_sync (
      .clk     (clk),
      .rst     (rst),
      .div_clk (div_clk),
      .tick    (tick)
   );

   // One tick's worth of work, in order: move, spawn, collide, then summarise.
   always_comb begin
      slots_n  = slots_q;
      cd_n     = cd_q;
      hit_n    = 1'b0;
      drop_n   = 1'b0;
      map_n    = '0;
      cnt_n    = '0;
      spawned  = 1'b0;
      spawn_ok = 1'b0;

      for (int i = 0; i < NUM_BULLETS; i++) begin
         if (slots_n[i].valid) begin
            if (slots_n[i].col == MAX_COL) slots_n[i].valid = 1'b0;
            else                           slots_n[i].col   = slots_n[i].col + 3'd1;
         end
      end

      // A spawn from the last column would leave the grid at once, so it is
      // silently ignored rather than reported as a drop.
      spawn_ok = bus.fire_req && (cd_q == 4'd0) && (bus.enemy_col != MAX_COL);
      for (int i = 0; i < NUM_BULLETS; i++) begin
         if (spawn_ok && !spawned && !slots_n[i].valid) begin
            slots_n[i] = '{valid: 1'b1, row: bus.enemy_row, col: bus.enemy_col + 3'd1};
            spawned    = 1'b1;
         end
      end

      if (spawned)             cd_n = 4'(COOLDOWN);
      else if (cd_q != 4'd0)   cd_n = cd_q - 4'd1;
      drop_n = bus.fire_req && (bus.enemy_col != MAX_COL) && !spawned;

`ifdef ENEMY_BULLET_HIT_EN
      for (int i = 0; i < NUM_BULLETS; i++) begin
         if (slots_n[i].valid && slots_n[i].row == bus.player_row &&
             slots_n[i].col == bus.player_col) begin
            slots_n[i].valid = 1'b0;
            hit_n            = 1'b1;
         end
      end
`endif

      for (int i = 0; i < NUM_BULLETS; i++) begin
         if (slots_n[i].valid) begin
            map_n[{slots_n[i].row, slots_n[i].col}] = 1'b1;
            cnt_n = cnt_n + 4'd1;
         end
      end
   end

`ifndef ENEMY_BULLET_HIT_EN
   logic unused_player;
   assign unused_player = ^{bus.player_row, bus.player_col};
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_BULLETS; i++) slots_q[i] <= '0;
         cd_q   <= '0;
         map_q  <= '0;
         cnt_q  <= '0;
         hit_q  <= 1'b0;
         drop_q <= 1'b0;
      end else if (tick) begin
         slots_q <= slots_n;
         cd_q    <= cd_n;
         map_q   <= map_n;
         cnt_q   <= cnt_n;
         hit_q   <= hit_n;
         drop_q  <= drop_n;
      end else begin
         hit_q  <= 1'b0;
         drop_q <= 1'b0;
      end
   end

   assign bus.bullet_map = map_q;
   assign bus.active_cnt = cnt_q;
   assign bus.player_hit = hit_q;
   assign bus.fire_drop  = drop_q;

endmodule
